mole_field_core: RTL
====================

MOLE_FIELD_CORE -- requirements
Module: mole_field_core

Interface
REQ-001 SHALL have parameter N_MOLES, default 4, number of mole cells (1..16).
REQ-002 SHALL have parameter STEP_DIV, default 10000000, clk cycles per game step.
REQ-003 SHALL have parameter LIFE_STEPS, default 8, steps a lit mole stays lit before expiring.
REQ-004 SHALL have parameter ROUND_STEPS, default 60, steps per round.
REQ-005 SHALL have parameter SCORE_W, default 8, score width.
REQ-006 SHALL have parameter SPAWN_TH, default 4, spawn threshold (0..16) compared with a 4-bit random draw.
REQ-007 SHALL have parameter MISS_PENALTY, default 1, where 1 means a hit on an unlit mole costs one point.
REQ-008 SHALL have parameter SEED, default 16'hACE1, the LFSR reset value (nonzero).
REQ-009 SHALL have port clk, input, 1 bit, the single clock.
REQ-010 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-011 SHALL have port start, input, 1 bit, a level that is internally rising-edge detected to start or restart a round.
REQ-012 SHALL have port hit, input, N_MOLES bits, one switch level per mole, each internally rising-edge detected.
REQ-013 SHALL have port mole, output, N_MOLES bits, 1 = mole lit.
REQ-014 SHALL have port score, output, SCORE_W bits, the current score.
REQ-015 SHALL have port time_left, output, 8 bits, remaining steps in the round.
REQ-016 SHALL have port state, output, 2 bits, with IDLE=0, PLAY=1, OVER=2.
REQ-017 SHALL have port step_pulse, output, 1 bit, one-cycle strobe at each game step.

Function
REQ-018 SHALL count clk cycles 0..STEP_DIV-1 and assert step_pulse for the single cycle the count wraps; the divider SHALL run only in PLAY.
REQ-019 SHALL implement FSM transitions: IDLE->PLAY on start edge; PLAY->OVER on the step where time_left reaches 0; OVER->PLAY on start edge.
REQ-020 SHALL, on a start edge in any state, clear score, load time_left=ROUND_STEPS, clear mole and all age counters, clear the divider and enter PLAY in the next cycle; the LFSR SHALL NOT be reseeded.
REQ-021 SHALL, on each step in PLAY, decrement time_left and advance the 16-bit Fibonacci LFSR one shift (taps 16,14,13,11).
REQ-022 SHALL, on each step, compute idx = lfsr[3:0] mod N_MOLES and light mole[idx] if it is unlit and lfsr[15:12] < SPAWN_TH, with its age set to 0.
REQ-023 SHALL, on each step, increment the age of every lit mole; a mole whose age reaches LIFE_STEPS SHALL clear and cost one point.
REQ-024 SHALL, in PLAY, clear mole[i] and add 1 to score in the same cycle as a hit[i] rising edge while mole[i] is lit.
REQ-025 SHALL, in PLAY, subtract MISS_PENALTY on a hit[i] rising edge while mole[i] is unlit.
REQ-026 SHALL apply all hits, misses and expiries in one cycle as a single net delta, clamped to 0..2^SCORE_W-1 (no wrap).
REQ-027 SHALL let a hit win over a same-cycle expiry of the same mole, giving +1 and no expiry penalty.
REQ-028 SHALL never let a same-cycle spawn take effect on a mole that is hit or expired in that cycle.
REQ-029 SHALL, on entry to OVER, clear mole, hold score, ignore hit and keep step_pulse low.
REQ-030 SHALL hold all outputs constant in IDLE and OVER except on a start edge.

Reset
REQ-031 SHALL set, while reset=0, state=IDLE, mole=0, score=0, time_left=0, step_pulse=0, the divider to 0, lfsr=SEED, all edge-detect history to 0 and all ages to 0.
REQ-032 SHALL abort an in-progress round when reset is asserted mid-round, with no residual state.
REQ-033 SHALL return outputs to their reset values asynchronously.
REQ-034 SHALL leave reset release synchronous to clk and not itself count as a start edge.

Structure
REQ-035 SHALL place the state encoding, LFSR tap mask and default parameter constants in shared package mole_pkg.
REQ-036 SHALL implement the LFSR as sub-module mole_lfsr (ports: clk, reset, en, seed, value).
REQ-037 SHALL keep score clamping and hit/miss/expiry accumulation in mole_field_core.

Verification (bench parameters: STEP_DIV=4, LIFE_STEPS=3, ROUND_STEPS=5, SCORE_W=4, SPAWN_TH=16)
REQ-038 SHALL cover: reset=0 then start pulse -> state=1, time_left=5; after 20 cycles state=2 and mole=0.
REQ-039 SHALL cover: a mole lit with hit[idx] held high for 3 cycles -> score +1 exactly once and mole[idx]=0 the next cycle.
REQ-040 SHALL cover: at score=0, a hit on an unlit mole -> score stays 0; at score=15, two simultaneous valid hits -> score stays 15.
REQ-041 SHALL cover: a lit mole left unhit for 3 steps -> it clears and score drops by 1; a hit in the expiry cycle instead -> score +1.
REQ-042 SHALL cover: start edge mid-round at time_left=2, score=3 -> next cycle score=0, time_left=5, mole=0.
REQ-043 SHALL cover: reset=0 asserted mid-round -> all outputs equal reset values before the next clk edge.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole field core.
// Holds the game state encoding, the LFSR feedback tap mask, the default
// parameter values and the single-step LFSR helper.
package mole_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } mole_state_e;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bit 15 = tap 16).
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned DefNMoles     = 4;
  localparam int unsigned DefStepDiv    = 10000000;
  localparam int unsigned DefLifeSteps  = 8;
  localparam int unsigned DefRoundSteps = 60;
  localparam int unsigned DefScoreW     = 8;
  localparam int unsigned DefSpawnTh    = 4;
  localparam int unsigned DefMissPen    = 1;
  localparam logic [15:0] DefSeed       = 16'hACE1;

  function automatic logic [15:0] lfsr_shift(input logic [15:0] v);
    return {v[14:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR used as the spawn random source.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset, loads seed
//   en    - advance one shift this cycle
//   seed  - reset value (must be nonzero)
//   value - current register contents
module mole_lfsr
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= seed;
    end else if (en) begin
      value_q <= lfsr_shift(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mole_field_core.sv
// Whack-a-mole game core: step divider, round FSM, mole spawn/age/expiry,
// edge-detected hits and a saturating score.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-low reset
//   start      - level, rising edge starts or restarts a round
//   hit        - one switch level per mole, rising edges count as hits
//   mole       - lit moles
//   score      - current score (saturates at both ends)
//   time_left  - remaining steps in the round
//   state      - IDLE=0, PLAY=1, OVER=2
//   step_pulse - one-cycle strobe on each game step
module mole_field_core
  import mole_pkg::*;
#(
  parameter int unsigned N_MOLES      = DefNMoles,
  parameter int unsigned STEP_DIV     = DefStepDiv,
  parameter int unsigned LIFE_STEPS   = DefLifeSteps,
  parameter int unsigned ROUND_STEPS  = DefRoundSteps,
  parameter int unsigned SCORE_W      = DefScoreW,
  parameter int unsigned SPAWN_TH     = DefSpawnTh,
  parameter int unsigned MISS_PENALTY = DefMissPen,
  parameter logic [15:0] SEED         = DefSeed
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] hit,
  output logic [N_MOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic [1:0]         state,
  output logic               step_pulse
);

  localparam int unsigned DivW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned AgeW     = (LIFE_STEPS > 1) ? $clog2(LIFE_STEPS + 1) : 1;
  localparam int          ScoreMax = (1 << SCORE_W) - 1;

  mole_state_e        state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [7:0]         time_q, time_d;
  logic [N_MOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [AgeW-1:0]    age_q [N_MOLES];
  logic [AgeW-1:0]    age_d [N_MOLES];
  logic               start_q;
  logic [N_MOLES-1:0] hit_q;

  logic               start_edge;
  logic [N_MOLES-1:0] hit_edge;
  logic               step;
  logic               spawn_ok;
  int unsigned        spawn_idx;
  logic [15:0]        lfsr_val;
  int                 n_plus, n_minus, sum;

  assign start_edge = start & ~start_q;
  assign hit_edge   = hit & ~hit_q;
  assign step       = (state_q == StPlay) && (div_q == DivW'(STEP_DIV - 1));
  assign spawn_idx  = int'(lfsr_val[3:0]) % N_MOLES;
  assign spawn_ok   = ({28'd0, lfsr_val[15:12]} < SPAWN_TH);

  // A restart cycle does not consume a random draw.
  mole_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (step && !start_edge),
    .seed  (SEED),
    .value (lfsr_val)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    time_d  = time_q;
    mole_d  = mole_q;
    age_d   = age_q;
    score_d = score_q;
    n_plus  = 0;
    n_minus = 0;
    sum     = 0;
    if (start_edge) begin
      state_d = StPlay;
      div_d   = '0;
      time_d  = 8'(ROUND_STEPS);
      mole_d  = '0;
      score_d = '0;
      for (int i = 0; i < N_MOLES; i++) age_d[i] = '0;
    end else if (state_q == StPlay) begin
      div_d = step ? '0 : div_q + DivW'(1);
      for (int i = 0; i < N_MOLES; i++) begin
        // A hit is checked first so it pre-empts a same-cycle expiry.
        if (hit_edge[i]) begin
          if (mole_q[i]) begin
            n_plus    = n_plus + 1;
            mole_d[i] = 1'b0;
            age_d[i]  = '0;
          end else begin
            n_minus = n_minus + int'(MISS_PENALTY);
          end
        end else if (step && mole_q[i]) begin
          if (age_q[i] == AgeW'(LIFE_STEPS - 1)) begin
            mole_d[i] = 1'b0;
            age_d[i]  = '0;
            n_minus   = n_minus + 1;
          end else begin
            age_d[i] = age_q[i] + AgeW'(1);
          end
        end
        // Spawn only into a mole that was dark and untouched this cycle.
        if (step && spawn_ok && (i == int'(spawn_idx)) && !mole_q[i] && !hit_edge[i]) begin
          mole_d[i] = 1'b1;
          age_d[i]  = '0;
        end
      end
      sum = int'({1'b0, score_q}) + n_plus - n_minus;
      if (sum < 0) begin
        score_d = '0;
      end else if (sum > ScoreMax) begin
        score_d = SCORE_W'(ScoreMax);
      end else begin
        score_d = sum[SCORE_W-1:0];
      end
      if (step) begin
        time_d = (time_q != 8'd0) ? time_q - 8'd1 : 8'd0;
        if (time_q <= 8'd1) begin
          state_d = StOver;
          mole_d  = '0;
          for (int i = 0; i < N_MOLES; i++) age_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      time_q  <= '0;
      mole_q  <= '0;
      score_q <= '0;
      start_q <= 1'b0;
      hit_q   <= '0;
      for (int i = 0; i < N_MOLES; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      time_q  <= time_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      start_q <= start;
      hit_q   <= hit;
      for (int i = 0; i < N_MOLES; i++) age_q[i] <= age_d[i];
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign state      = state_q;
  assign step_pulse = step;

endmodule
